swap_sequencer: RTL

- Sequences the existing 20-bit `swap_module` datapath so that two register-file entries are exchanged in place.
- Accepts one request (addresses A, B) via valid/ready handshake.
- Drives a single-port synchronous-read register file: read A, read B, write A<=old B, write B<=old A.
- Sits between the URCPU decode/execute stage (source of swap instructions) and the register file port.

---
 rtl/swap_seq_pkg.sv | 18 +
 rtl/swap_module.sv | 14 +
 rtl/swap_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/swap_seq_pkg.sv
// Shared types and default widths for the swap sequencer.
package swap_seq_pkg;

  localparam int unsigned DataWDefault = 20;
  localparam int unsigned AddrWDefault = 4;

  // Sequencer states; encodings are fixed so they read the same in waveforms and docs.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRdA  = 3'd1,
    StRdB  = 3'd2,
    StCap  = 3'd3,
    StWrA  = 3'd4,
    StWrB  = 3'd5,
    StDone = 3'd6
  } state_e;

endpackage

// File: rtl/swap_module.sv
// Swap datapath: presents its two input words on the opposite outputs.
module swap_module #(
  parameter int unsigned DATA_W = 20
) (
  input  logic [DATA_W-1:0] input_a,
  input  logic [DATA_W-1:0] input_b,
  output logic [DATA_W-1:0] output_a,
  output logic [DATA_W-1:0] output_b
);

  assign output_a = input_b;
  assign output_b = input_a;

endmodule

// File: rtl/swap_sequencer.sv
// Exchanges two register-file entries in place through a single-port, synchronous-read
// register file: read A, read B, write A <= old B, write B <= old A, then pulse done.
// Optional macro SWAP_SEQ_SAME_ADDR_SKIP_EN: a request with equal addresses skips all
// register-file traffic and goes straight to done.
module swap_sequencer
  import swap_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_re,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_a_q, addr_b_q, addr_hold_q;
  logic [DATA_W-1:0] word_a_q, word_b_q, wdata_hold_q;
  logic [DATA_W-1:0] swap_out_a, swap_out_b;
  logic              handshake;

  assign handshake = req_valid && (state_q == StIdle);

  swap_module #(
    .DATA_W (DATA_W)
  ) u_swap (
    .input_a  (word_a_q),
    .input_b  (word_b_q),
    .output_a (swap_out_a),
    .output_b (swap_out_b)
  );

`ifdef SWAP_SEQ_SAME_ADDR_SKIP_EN
  logic same_addr;
  assign same_addr = (req_addr_a == req_addr_b);
`endif

  // Next-state sequencing: a fixed walk through the swap once a request is accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
`ifdef SWAP_SEQ_SAME_ADDR_SKIP_EN
          state_d = same_addr ? StDone : StRdA;
`else
          state_d = StRdA;
`endif
        end
      end
      StRdA:   state_d = StRdB;
      StRdB:   state_d = StCap;
      StCap:   state_d = StWrA;
      StWrA:   state_d = StWrB;
      StWrB:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from state and registered values only; unused rf_addr/rf_wdata hold.
  always_comb begin
    req_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    rf_re     = 1'b0;
    rf_we     = 1'b0;
    rf_addr   = addr_hold_q;
    rf_wdata  = wdata_hold_q;
    unique case (state_q)
      StRdA: begin
        rf_re   = 1'b1;
        rf_addr = addr_a_q;
      end
      StRdB: begin
        rf_re   = 1'b1;
        rf_addr = addr_b_q;
      end
      StWrA: begin
        rf_we    = 1'b1;
        rf_addr  = addr_a_q;
        rf_wdata = swap_out_a;
      end
      StWrB: begin
        rf_we    = 1'b1;
        rf_addr  = addr_b_q;
        rf_wdata = swap_out_b;
      end
      default: ;
    endcase
  end

  // State, latched request, captured words and held RF address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      word_a_q     <= '0;
      word_b_q     <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_hold_q  <= rf_addr;
      wdata_hold_q <= rf_wdata;
      if (handshake) begin
        addr_a_q <= req_addr_a;
        addr_b_q <= req_addr_b;
      end
      // Read data lags the read enable by one cycle.
      if (state_q == StRdB) word_a_q <= rf_rdata;
      if (state_q == StCap) word_b_q <= rf_rdata;
    end
  end

endmodule
